// File: rtl/pc_seq.sv
// pc_seq: front-of-fetch program counter with stall, absolute/relative jumps and an
// optional call/return stack that is compiled in only when PC_RET_STACK_EN is defined.
module pc_seq #(
  parameter int           D          = 12,
  parameter int           DEPTH      = 4,
  parameter int           OFFW       = 8,
  parameter logic [D-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       nextFlag,
  input  logic                       absjump_en,
  input  logic [D-1:0]               target,
  input  logic                       reljump_en,
  input  logic [OFFW-1:0]            offset,
  input  logic                       call_en,
  input  logic                       ret_en,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  localparam int SW = $clog2(DEPTH+1);

  logic [D-1:0]           pc_q, pc_d;
  logic [D-1:0]           pc_inc, pc_rel;
  logic signed [OFFW-1:0] off_s;

  assign pc_inc = pc_q + D'(1);
  assign off_s  = offset;
  // Size-casting a signed operand sign-extends, so this also covers OFFW == D.
  assign pc_rel = pc_q + D'(off_s);

`ifdef PC_RET_STACK_EN

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]  stack_q [DEPTH];
  logic [SW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          full, empty, push;
  logic [AW-1:0] top_idx, push_idx;

  assign full     = (depth_q == SW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign top_idx  = AW'(depth_q - SW'(1));
  assign push_idx = AW'(depth_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (nextFlag) begin
      if (ret_en) begin
        if (!empty) begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - SW'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call_en) begin
        pc_d = target;
        if (!full) begin
          push    = 1'b1;
          depth_d = depth_q + SW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (absjump_en) begin
        pc_d = target;
      end else if (reljump_en) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage has no reset; entries above depth_q are never read.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  assign stack_depth = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

`else

  // Without a stack, a call is a plain jump and a return is a plain increment.
  always_comb begin
    pc_d = pc_q;
    if (nextFlag) begin
      if (ret_en) begin
        pc_d = pc_inc;
      end else if (call_en || absjump_en) begin
        pc_d = target;
      end else if (reljump_en) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign stack_depth = '0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_ADDR;
    else        pc_q <= pc_d;
  end

  assign prog_ctr = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue-based stack model predicts each edge's outputs,
// which are pushed when stimulus is driven and popped after the edge for comparison.
module tb_pc_seq;

  localparam int D     = 12;
  localparam int DEPTH = 4;
  localparam int OFFW  = 8;
`ifdef PC_RET_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct {
    logic [D-1:0] pc;
    int           depth;
    logic         full;
    logic         empty;
    logic         err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            next_flag, abs_en, rel_en, call, ret;
  logic [D-1:0]    tgt;
  logic [OFFW-1:0] off;
  logic [D-1:0]    prog_ctr;
  logic [2:0]      stack_depth;
  logic            stack_full, stack_empty, stack_err;

  int n_vec = 0;
  int n_err = 0;

  exp_t         sb_q[$];
  logic [D-1:0] m_pc;
  logic [D-1:0] m_stk[$];
  logic         m_err;

  pc_seq #(.D(D), .DEPTH(DEPTH), .OFFW(OFFW), .RESET_ADDR(12'h000)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .nextFlag   (next_flag),
    .absjump_en (abs_en),
    .target     (tgt),
    .reljump_en (rel_en),
    .offset     (off),
    .call_en    (call),
    .ret_en     (ret),
    .prog_ctr   (prog_ctr),
    .stack_depth(stack_depth),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 12'h000;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Drive one cycle of controls, predict the outcome, then compare after the edge.
  task automatic step(input string tag, input bit nf, input bit r, input bit c,
                      input bit a, input bit rl, input logic [D-1:0] t,
                      input logic [OFFW-1:0] o);
    exp_t         e, got;
    logic [D-1:0] inc;
    next_flag = nf; ret = r; call = c; abs_en = a; rel_en = rl; tgt = t; off = o;
    inc = m_pc + 12'd1;
    if (nf) begin
      if (r) begin
        if (STK && m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc = inc;
          if (STK) m_err = 1'b1;
        end
      end else if (c) begin
        if (STK) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(inc);
          else m_err = 1'b1;
        end
        m_pc = t;
      end else if (a) begin
        m_pc = t;
      end else if (rl) begin
        m_pc = m_pc + {{(D-OFFW){o[OFFW-1]}}, o};
      end else begin
        m_pc = inc;
      end
    end
    e.pc    = m_pc;
    e.depth = m_stk.size();
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".pc"},    32'(prog_ctr),    32'(got.pc));
    check({tag, ".depth"}, 32'(stack_depth), 32'(got.depth));
    check({tag, ".full"},  32'(stack_full),  32'(got.full));
    check({tag, ".empty"}, 32'(stack_empty), 32'(got.empty));
    check({tag, ".err"},   32'(stack_err),   32'(got.err));
  endtask

  task automatic inc_step(input string tag);
    step(tag, 1, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic jump(input logic [D-1:0] t);
    step("jump", 1, 0, 0, 1, 0, t, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    {next_flag, abs_en, rel_en, call, ret} = '0;
    tgt = '0;
    off = '0;
    model_reset();
    #1;
    check("rst.pc",    32'(prog_ctr),    32'h0);
    check("rst.depth", 32'(stack_depth), 32'h0);
    check("rst.empty", 32'(stack_empty), 32'h1);
    check("rst.full",  32'(stack_full),  32'h0);
    check("rst.err",   32'(stack_err),   32'h0);
    #11 rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      inc_step("incr");
      check("incr.abs", 32'(prog_ctr), 32'(i));
    end

    jump(12'hFFE);
    check("wrap0", 32'(prog_ctr), 32'hFFE);
    inc_step("wrap");
    check("wrap1", 32'(prog_ctr), 32'hFFF);
    inc_step("wrap");
    check("wrap2", 32'(prog_ctr), 32'h000);

    jump(12'h010);
    step("rel", 1, 0, 0, 0, 1, '0, 8'hF0);
    check("rel_neg", 32'(prog_ctr), 32'h000);
    jump(12'h010);
    step("rel", 1, 0, 0, 0, 1, '0, 8'h7F);
    check("rel_pos", 32'(prog_ctr), 32'h08F);
    jump(12'h005);
    step("rel", 1, 0, 0, 0, 1, '0, 8'hF0);
    check("rel_wrap", 32'(prog_ctr), 32'hFF5);

    jump(12'h020);
    step("call", 1, 0, 1, 0, 0, 12'h100, '0);
    check("call.pc", 32'(prog_ctr), 32'h100);
    step("ret", 1, 1, 0, 0, 0, '0, '0);
    check("ret.pc", 32'(prog_ctr), STK ? 32'h021 : 32'h101);
    step("call2", 1, 0, 1, 0, 0, 12'h200, '0);
    step("call3", 1, 0, 1, 0, 0, 12'h300, '0);
    step("retcall", 1, 1, 1, 0, 0, 12'h700, '0);
    step("ret2", 1, 1, 0, 0, 0, '0, '0);

    for (int i = 1; i <= 5; i++) step("ovf_call", 1, 0, 1, 0, 0, 12'(i * 256), '0);
    check("ovf.pc", 32'(prog_ctr), 32'h500);
    for (int i = 0; i < 5; i++) step("unf_ret", 1, 1, 0, 0, 0, '0, '0);

    for (int i = 0; i < 3; i++) step("stall", 0, 0, 1, 1, 1, 12'h3A5, 8'h11);

    jump(12'h123);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.pc",    32'(prog_ctr),    32'h0);
    check("midrst.depth", 32'(stack_depth), 32'h0);
    check("midrst.err",   32'(stack_err),   32'h0);
    #3 rst_n = 1'b1;
    inc_step("post_rst");
    check("post_rst.abs", 32'(prog_ctr), 32'h1);

    for (int i = 0; i < 60; i++) begin
      step("rand", $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, 12'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
